// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port 16K x 16 video RAM between the scanline
// fetch engine (strict priority) and the CPU bus (stb/ack, word or byte writes).
module vram_arbiter #(
    parameter int unsigned AW = 14
) (
    input  logic          clk_sys,
    input  logic          reset,
    // video fetch port
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [15:0]   vid_data,
    output logic          vid_valid,
    output logic          vid_ovr,
    // CPU bus port
    input  logic          cpu_stb,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_wtbt,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_din,
    output logic [15:0]   cpu_dout,
    output logic          cpu_ack,
    // physical RAM port
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_wdata,
    output logic          ram_we,
    output logic [1:0]    ram_be,
    input  logic [15:0]   ram_rdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VISSUE = 3'd1;
    localparam logic [2:0] S_VCAP   = 3'd2;
    localparam logic [2:0] S_CISSUE = 3'd3;
    localparam logic [2:0] S_CCAP   = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic          vid_take_c;
    logic          cpu_take_c;

    logic          vid_pend;
    logic [AW-1:0] vid_addr_q;
    logic          cpu_pend;
    logic          cpu_arm;

    // State register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant decode; video always wins in IDLE
    always_comb begin
        state_nxt  = state;
        vid_take_c = 1'b0;
        cpu_take_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (vid_pend) begin
                    vid_take_c = 1'b1;
                    state_nxt  = S_VISSUE;
                end else if (cpu_pend) begin
                    cpu_take_c = 1'b1;
                    state_nxt  = S_CISSUE;
                end
            end
            S_VISSUE: state_nxt = S_VCAP;
            S_VCAP:   state_nxt = S_IDLE;
            S_CISSUE: state_nxt = S_CCAP;
            S_CCAP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Request capture; cpu_arm blocks re-triggering until the strobe has dropped
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vid_pend   <= 1'b0;
            vid_addr_q <= '0;
            vid_ovr    <= 1'b0;
            cpu_pend   <= 1'b0;
            cpu_arm    <= 1'b0;
        end else begin
            if (vid_req) begin
                vid_pend   <= 1'b1;
                vid_addr_q <= vid_addr;
                if (vid_pend) begin
                    vid_ovr <= 1'b1;
                end
            end else if (vid_take_c) begin
                vid_pend <= 1'b0;
            end

            if (cpu_take_c) begin
                cpu_pend <= 1'b0;
            end
            if (!cpu_stb) begin
                cpu_arm <= 1'b1;
            end else if (cpu_arm && !cpu_ack) begin
                cpu_pend <= 1'b1;
                cpu_arm  <= 1'b0;
            end
        end
    end

    // RAM issue and read-data capture for both requesters
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            ram_be    <= 2'b00;
            vid_data  <= '0;
            vid_valid <= 1'b0;
            cpu_dout  <= '0;
            cpu_ack   <= 1'b0;
        end else begin
            vid_valid <= 1'b0;

            if (vid_take_c) begin
                ram_addr <= vid_addr_q;
                ram_we   <= 1'b0;
            end else if (cpu_take_c) begin
                ram_addr  <= cpu_addr;
                ram_wdata <= cpu_din;
                ram_we    <= cpu_we;
                ram_be    <= (cpu_wtbt == 2'b00) ? 2'b11 : cpu_wtbt;
            end

            if (state == S_CISSUE) begin
                ram_we <= 1'b0;
            end

            if (state == S_VCAP) begin
                vid_data  <= ram_rdata;
                vid_valid <= 1'b1;
            end

            if (state == S_CCAP) begin
                cpu_dout <= ram_rdata;
                cpu_ack  <= 1'b1;
            end else if (!cpu_stb) begin
                cpu_ack <= 1'b0;
            end
        end
    end

endmodule
